// File: rtl/qisp_mem_pkg.sv
// Shared definitions for the instruction-fetch memory responder: FSM encoding and default widths.
package qisp_mem_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int QISP_ADDR_W = 16;
    localparam int QISP_DATA_W = 16;

endpackage

// File: rtl/mem_word_store.sv
// Word-addressed register array: one synchronous write port, one combinational read port.
module mem_word_store #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_wadr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_radr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

    // No reset: the program image must survive a core reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wadr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_radr];

endmodule

// File: rtl/i_mem_responder.sv
// Instruction-fetch responder: serves the word at the presented address after a fixed latency,
// restarting whenever the word index changes; the store can be preloaded at any time.
module i_mem_responder
    import qisp_mem_pkg::*;
#(
    parameter int ADDR_W     = QISP_ADDR_W,
    parameter int DATA_W     = QISP_DATA_W,
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic [ADDR_W-1:0]     i_mem_adr,
    output logic                  i_mem_rdy,
    output logic [DATA_W-1:0]     i_mem_data,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_adr,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  o_dbg_state
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_last_idx;
    logic                  r_rdy;
    logic [DATA_W-1:0]     r_data;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_we;
    logic                  w_unused_adr;

    // Byte address to word index; bit 0 and the high bits alias.
    assign w_idx        = i_mem_adr[DEPTH_LOG2:1];
    assign w_unused_adr = ^{i_mem_adr[ADDR_W-1:DEPTH_LOG2+1], i_mem_adr[0]};

    // Preload writes are dropped while reset is held.
    assign w_we = ld_we & a_rst;

    mem_word_store #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_wadr  (ld_adr),
        .i_wdata (ld_data),
        .i_radr  (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            r_state    <= ST_FETCH;
            r_cnt      <= 4'd0;
            r_last_idx <= '0;
            r_rdy      <= 1'b0;
            r_data     <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_idx != r_last_idx) begin
                        r_last_idx <= w_idx;
                        r_cnt      <= 4'd1;
                    end else if (r_cnt >= LAT_M1) begin
                        // Store read happens here, so a write landing on this same edge is not seen.
                        r_data  <= w_rdata;
                        r_rdy   <= 1'b1;
                        r_state <= ST_READY;
                    end else if (r_cnt != 4'hF) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_READY: begin
                    if (w_idx != r_last_idx) begin
                        r_rdy      <= 1'b0;
                        r_last_idx <= w_idx;
                        r_cnt      <= 4'd1;
                        r_state    <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign i_mem_rdy   = r_rdy;
    assign i_mem_data  = r_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i_mem_responder.sv
// Directed bench for i_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance share stimulus.
module tb_i_mem_responder;

    logic        clk;
    logic        a_rst;
    logic [15:0] i_mem_adr;
    logic        ld_we;
    logic [3:0]  ld_adr;
    logic [15:0] ld_data;
    logic        rdy;
    logic [15:0] data;
    logic        dbg;
    logic        rdy1;
    logic [15:0] data1;
    logic        dbg1;

    int n_cmp;
    int n_err;

    i_mem_responder #(.LATENCY(2)) u_dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .i_mem_adr   (i_mem_adr),
        .i_mem_rdy   (rdy),
        .i_mem_data  (data),
        .ld_we       (ld_we),
        .ld_adr      (ld_adr),
        .ld_data     (ld_data),
        .o_dbg_state (dbg)
    );

    i_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk         (clk),
        .a_rst       (a_rst),
        .i_mem_adr   (i_mem_adr),
        .i_mem_rdy   (rdy1),
        .i_mem_data  (data1),
        .ld_we       (ld_we),
        .ld_adr      (ld_adr),
        .ld_data     (ld_data),
        .o_dbg_state (dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge and settle; inputs driven afterwards are stable for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst     = 1'b0;
        ld_we     = 1'b0;
        ld_adr    = 4'd0;
        ld_data   = 16'h0000;
        i_mem_adr = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (rdy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_rdy cycle %0d: got %b want 0", i, rdy);
            end
            n_cmp++;
            if (data !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_data cycle %0d: got %h want 0000", i, data);
            end
        end
    endtask

    task automatic test_preload();
        logic [15:0] words [4];
        words[0] = 16'h2240;
        words[1] = 16'h0050;
        words[2] = 16'h8190;
        words[3] = 16'h0493;
        a_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_we   = 1'b1;
            ld_adr  = 4'(i);
            ld_data = words[i];
            step();
        end
        ld_we = 1'b0;
        step();
    endtask

    // Reset again with a write attempt that must be dropped, then release with adr=0.
    task automatic test_first_fetch();
        a_rst     = 1'b0;
        i_mem_adr = 16'h0000;
        ld_we     = 1'b1;
        ld_adr    = 4'd0;
        ld_data   = 16'hDEAD;
        step();
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_err++;
            $display("FAIL rerst_rdy: got %b want 0", rdy);
        end
        a_rst = 1'b1;
        ld_we = 1'b0;
        step();
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_err++;
            $display("FAIL first_fetch_early_rdy: got %b want 0", rdy);
        end
        n_cmp++;
        if (rdy1 !== 1'b1 || data1 !== 16'h2240) begin
            n_err++;
            $display("FAIL lat1_first_fetch: got rdy=%b data=%h want rdy=1 data=2240", rdy1, data1);
        end
        step();
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_err++;
            $display("FAIL first_fetch_rdy: got %b want 1", rdy);
        end
        n_cmp++;
        if (data !== 16'h2240) begin
            n_err++;
            $display("FAIL first_fetch_data: got %h want 2240", data);
        end
        n_cmp++;
        if (dbg !== 1'b1) begin
            n_err++;
            $display("FAIL first_fetch_state: got %b want 1", dbg);
        end
    endtask

    task automatic test_addr_change();
        i_mem_adr = 16'h0002;
        step();
        n_cmp++;
        if (rdy !== 1'b0 || data !== 16'h2240) begin
            n_err++;
            $display("FAIL change_drop: got rdy=%b data=%h want rdy=0 data=2240", rdy, data);
        end
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h0050) begin
            n_err++;
            $display("FAIL change_serve: got rdy=%b data=%h want rdy=1 data=0050", rdy, data);
        end
    endtask

    task automatic test_back_to_back();
        i_mem_adr = 16'h0004;
        step();
        n_cmp++;
        if (rdy !== 1'b0 || data !== 16'h0050) begin
            n_err++;
            $display("FAIL b2b_first: got rdy=%b data=%h want rdy=0 data=0050", rdy, data);
        end
        i_mem_adr = 16'h0006;
        step();
        n_cmp++;
        if (rdy !== 1'b0 || data !== 16'h0050) begin
            n_err++;
            $display("FAIL b2b_restart: got rdy=%b data=%h want rdy=0 data=0050", rdy, data);
        end
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h0493) begin
            n_err++;
            $display("FAIL b2b_serve: got rdy=%b data=%h want rdy=1 data=0493", rdy, data);
        end
    endtask

    task automatic test_preload_hazards();
        i_mem_adr = 16'h0000;
        step();
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h2240) begin
            n_err++;
            $display("FAIL hz_word0: got rdy=%b data=%h want rdy=1 data=2240", rdy, data);
        end
        // Write the word being fetched during FETCH: new value is served.
        i_mem_adr = 16'h0006;
        ld_we     = 1'b1;
        ld_adr    = 4'd3;
        ld_data   = 16'hBEEF;
        step();
        ld_we = 1'b0;
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'hBEEF) begin
            n_err++;
            $display("FAIL hz_fetch_write: got rdy=%b data=%h want rdy=1 data=beef", rdy, data);
        end
        // Rewrite while READY: output holds.
        ld_we   = 1'b1;
        ld_adr  = 4'd3;
        ld_data = 16'h1234;
        step();
        ld_we = 1'b0;
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'hBEEF) begin
            n_err++;
            $display("FAIL hz_ready_write: got rdy=%b data=%h want rdy=1 data=beef", rdy, data);
        end
        // Write on the same edge that raises rdy: old value wins.
        i_mem_adr = 16'h0000;
        step();
        ld_we   = 1'b1;
        ld_adr  = 4'd0;
        ld_data = 16'h5555;
        step();
        ld_we = 1'b0;
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h2240) begin
            n_err++;
            $display("FAIL hz_rbw: got rdy=%b data=%h want rdy=1 data=2240", rdy, data);
        end
    endtask

    task automatic test_alias();
        i_mem_adr = 16'h0022;
        step();
        n_cmp++;
        if (rdy !== 1'b0 || rdy1 !== 1'b0) begin
            n_err++;
            $display("FAIL alias_accept: got rdy=%b rdy1=%b want 0 0", rdy, rdy1);
        end
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h0050) begin
            n_err++;
            $display("FAIL alias_serve: got rdy=%b data=%h want rdy=1 data=0050", rdy, data);
        end
        n_cmp++;
        if (rdy1 !== 1'b1 || data1 !== 16'h0050) begin
            n_err++;
            $display("FAIL lat1_alias: got rdy=%b data=%h want rdy=1 data=0050", rdy1, data1);
        end
        // Same word index via bit 0 and a high bit: no refetch.
        i_mem_adr = 16'h8023;
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h0050) begin
            n_err++;
            $display("FAIL alias_hold: got rdy=%b data=%h want rdy=1 data=0050", rdy, data);
        end
    endtask

    task automatic test_reset_mid_fetch();
        i_mem_adr = 16'h0004;
        step();
        a_rst = 1'b0;
        step();
        n_cmp++;
        if (rdy !== 1'b0 || data !== 16'h0000) begin
            n_err++;
            $display("FAIL midrst: got rdy=%b data=%h want rdy=0 data=0000", rdy, data);
        end
        n_cmp++;
        if (dbg !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: got %b want 0", dbg);
        end
        a_rst     = 1'b1;
        i_mem_adr = 16'h0002;
        step();
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h0050) begin
            n_err++;
            $display("FAIL midrst_word1: got rdy=%b data=%h want rdy=1 data=0050", rdy, data);
        end
        i_mem_adr = 16'h0004;
        step();
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h8190) begin
            n_err++;
            $display("FAIL midrst_word2: got rdy=%b data=%h want rdy=1 data=8190", rdy, data);
        end
        i_mem_adr = 16'h0000;
        step();
        step();
        n_cmp++;
        if (rdy !== 1'b1 || data !== 16'h5555) begin
            n_err++;
            $display("FAIL midrst_word0: got rdy=%b data=%h want rdy=1 data=5555", rdy, data);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_preload();
        test_first_fetch();
        test_addr_change();
        test_back_to_back();
        test_preload_hazards();
        test_alias();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
